// File: rtl/cv32e40x_mult_arb_pkg.sv
// Shared types for the two-port multiplier arbiter: operator encoding, arbiter
// state constants and the held-request record.
package cv32e40x_mult_arb_pkg;

  typedef enum logic [2:0] {
    MUL_M32    = 3'd0,
    MUL_H      = 3'd1,
    MUL_CLMUL  = 3'd2,
    MUL_CLMULH = 3'd3,
    MUL_CLMULR = 3'd4
  } mul_opcode_e;

  typedef logic [1:0] mul_arb_state_e;

  localparam mul_arb_state_e ARB_IDLE = 2'd0;
  localparam mul_arb_state_e ARB_BUSY = 2'd1;
  localparam mul_arb_state_e ARB_RESP = 2'd2;

  typedef struct packed {
    mul_opcode_e op;
    logic [1:0]  sm;
    logic [31:0] a;
    logic [31:0] b;
  } mul_req_t;

  function automatic logic onehot0(logic [1:0] v);
    return ~&v;
  endfunction

endpackage

// File: rtl/cv32e40x_mult_arb_if.sv
// Request/response and multiplier-side bus of the arbiter. The slave modport is
// the arbiter's view; master is the view of the requesters plus the multiplier.
interface cv32e40x_mult_arb_if;
  import cv32e40x_mult_arb_pkg::*;

  logic [1:0]  req_valid_i;
  logic [1:0]  req_ready_o;
  mul_opcode_e req_operator_i    [2];
  logic [1:0]  req_signed_mode_i [2];
  logic [31:0] req_op_a_i        [2];
  logic [31:0] req_op_b_i        [2];
  logic [1:0]  req_kill_i;
  logic [1:0]  resp_valid_o;
  logic [1:0]  resp_ready_i;
  logic [31:0] resp_result_o;
  logic        mul_valid_o;
  mul_opcode_e mul_operator_o;
  logic [1:0]  mul_signed_mode_o;
  logic [31:0] mul_op_a_o;
  logic [31:0] mul_op_b_o;
  logic [31:0] mul_result_i;
  logic        mul_valid_i;
  logic        mul_ready_o;
  logic        busy_o;

  modport slave (
    input  req_valid_i, req_operator_i, req_signed_mode_i, req_op_a_i, req_op_b_i,
           req_kill_i, resp_ready_i, mul_result_i, mul_valid_i,
    output req_ready_o, resp_valid_o, resp_result_o, mul_valid_o, mul_operator_o,
           mul_signed_mode_o, mul_op_a_o, mul_op_b_o, mul_ready_o, busy_o
  );

  modport master (
    output req_valid_i, req_operator_i, req_signed_mode_i, req_op_a_i, req_op_b_i,
           req_kill_i, resp_ready_i, mul_result_i, mul_valid_i,
    input  req_ready_o, resp_valid_o, resp_result_o, mul_valid_o, mul_operator_o,
           mul_signed_mode_o, mul_op_a_o, mul_op_b_o, mul_ready_o, busy_o
  );

endinterface

// File: rtl/cv32e40x_rr_arb2.sv
// Two-input grant logic: round-robin against the last winner, or fixed
// priority to input 0 when RR_EN is 0. Purely combinational.
module cv32e40x_rr_arb2 #(
  parameter bit RR_EN = 1'b1
) (
  input  logic [1:0] eligible,
  input  logic       rr_last,
  output logic [1:0] grant
);

  // NOTE: assign a default first in every always_comb so no path leaves the
  // output unassigned, otherwise a latch is inferred.
  always_comb begin
    grant = 2'b00;
    case (eligible)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (RR_EN && !rr_last) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/cv32e40x_mult_arb.sv
// Shares one multiplier between the EX stage (port 0) and the extension path
// (port 1): grants, holds operands for the whole operation, buffers the result.
module cv32e40x_mult_arb
  import cv32e40x_mult_arb_pkg::*;
#(
  parameter bit RR_EN = 1'b1
) (
  input logic                 clk,
  input logic                 rst_n,
  cv32e40x_mult_arb_if.slave  bus
);

  mul_arb_state_e state_q, state_d;
  logic           owner_q;
  logic           rr_last_q;
  mul_req_t       hold_q;
  mul_req_t       req_sel;
  logic [31:0]    result_q;
  logic [1:0]     eligible;
  logic [1:0]     grant;
  logic [1:0]     owner_oh;
  logic           owner_kill;
  logic           gsel;

  assign eligible = bus.req_valid_i & ~bus.req_kill_i;

  cv32e40x_rr_arb2 #(.RR_EN(RR_EN)) u_rr_arb2 (
    .eligible (eligible),
    .rr_last  (rr_last_q),
    .grant    (grant)
  );

  assign gsel       = grant[1];
  assign owner_oh   = owner_q ? 2'b10 : 2'b01;
  assign owner_kill = bus.req_kill_i[owner_q];

  assign req_sel = '{op: bus.req_operator_i[gsel],
                     sm: bus.req_signed_mode_i[gsel],
                     a:  bus.req_op_a_i[gsel],
                     b:  bus.req_op_b_i[gsel]};

  // A kill from the owner always beats a completing multiply or an accepted response.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE: if (|grant) state_d = ARB_BUSY;
      ARB_BUSY: begin
        if (owner_kill)           state_d = ARB_IDLE;
        else if (bus.mul_valid_i) state_d = ARB_RESP;
      end
      ARB_RESP: if (owner_kill || bus.resp_ready_i[owner_q]) state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: the hold and result registers are reset too, because they drive
  // outputs that must read as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ARB_IDLE;
      owner_q   <= 1'b0;
      rr_last_q <= 1'b1;
      hold_q    <= '0;
      result_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ARB_IDLE && |grant) begin
        hold_q    <= req_sel;
        owner_q   <= gsel;
        rr_last_q <= gsel;
      end
      if (state_q == ARB_BUSY && !owner_kill && bus.mul_valid_i) begin
        result_q <= bus.mul_result_i;
      end
    end
  end

  assign bus.req_ready_o       = (state_q == ARB_IDLE) ? grant : 2'b00;
  assign bus.resp_valid_o      = (state_q == ARB_RESP && !owner_kill) ? owner_oh : 2'b00;
  assign bus.resp_result_o     = result_q;
  assign bus.mul_valid_o       = (state_q == ARB_BUSY);
  assign bus.mul_ready_o       = (state_q == ARB_BUSY);
  assign bus.mul_operator_o    = hold_q.op;
  assign bus.mul_signed_mode_o = hold_q.sm;
  assign bus.mul_op_a_o        = hold_q.a;
  assign bus.mul_op_b_o        = hold_q.b;
  assign bus.busy_o            = (state_q != ARB_IDLE);

  a_req_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    onehot0(bus.req_ready_o));

  a_resp_valid_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    onehot0(bus.resp_valid_o));

  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == ARB_BUSY) ##1 (state_q == ARB_BUSY) |-> $stable(hold_q));

  a_mul_valid_in_busy: assert property (@(posedge clk) disable iff (!rst_n)
    bus.mul_valid_i |-> (state_q == ARB_BUSY && bus.mul_valid_o));

endmodule

// File: tb/tb_cv32e40x_mult_arb.sv
// Self-checking bench for cv32e40x_mult_arb: a behavioural multiplier on each
// DUT, directed scenarios and a randomized run against an arithmetic reference.
module tb_cv32e40x_mult_arb;
  import cv32e40x_mult_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  cv32e40x_mult_arb_if a_if ();
  cv32e40x_mult_arb_if f_if ();

  cv32e40x_mult_arb #(.RR_EN(1'b1)) u_dut (.clk(clk), .rst_n(rst_n), .bus(a_if));
  cv32e40x_mult_arb #(.RR_EN(1'b0)) u_fix (.clk(clk), .rst_n(rst_n), .bus(f_if));

  // Reference arithmetic: signed_mode[0] marks op A signed, [1] marks op B signed.
  function automatic logic [31:0] mul_ref(mul_opcode_e op, logic [1:0] sm,
                                          logic [31:0] a, logic [31:0] b);
    logic signed [32:0] ea, eb;
    logic signed [65:0] p;
    logic [63:0] x;
    ea = {sm[0] & a[31], a};
    eb = {sm[1] & b[31], b};
    p  = ea * eb;
    x  = '0;
    for (int i = 0; i < 32; i++) if (b[i]) x = x ^ ({32'b0, a} << i);
    case (op)
      MUL_M32:    return a * b;
      MUL_H:      return p[63:32];
      MUL_CLMUL:  return x[31:0];
      MUL_CLMULH: return x[63:32];
      MUL_CLMULR: return x[62:31];
      default:    return 32'h0;
    endcase
  endfunction

  // Behavioural multipliers: single-cycle ops answer at once, MULH after 4 cycles.
  logic [2:0] mcnt_a, mcnt_f;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mcnt_a <= '0;
    else if (!a_if.mul_valid_o || a_if.mul_valid_i) mcnt_a <= '0;
    else mcnt_a <= mcnt_a + 3'd1;
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mcnt_f <= '0;
    else if (!f_if.mul_valid_o || f_if.mul_valid_i) mcnt_f <= '0;
    else mcnt_f <= mcnt_f + 3'd1;
  end

  assign a_if.mul_valid_i  = a_if.mul_valid_o && (a_if.mul_operator_o != MUL_H || mcnt_a == 3'd3);
  assign a_if.mul_result_i = a_if.mul_valid_i ?
    mul_ref(a_if.mul_operator_o, a_if.mul_signed_mode_o, a_if.mul_op_a_o, a_if.mul_op_b_o) : 32'h0;
  assign f_if.mul_valid_i  = f_if.mul_valid_o && (f_if.mul_operator_o != MUL_H || mcnt_f == 3'd3);
  assign f_if.mul_result_i = f_if.mul_valid_i ?
    mul_ref(f_if.mul_operator_o, f_if.mul_signed_mode_o, f_if.mul_op_a_o, f_if.mul_op_b_o) : 32'h0;

  // The fixed-priority copy sees the same requests and always accepts responses.
  assign f_if.req_valid_i          = a_if.req_valid_i;
  assign f_if.req_kill_i           = 2'b00;
  assign f_if.resp_ready_i         = 2'b11;
  assign f_if.req_operator_i[0]    = a_if.req_operator_i[0];
  assign f_if.req_operator_i[1]    = a_if.req_operator_i[1];
  assign f_if.req_signed_mode_i[0] = a_if.req_signed_mode_i[0];
  assign f_if.req_signed_mode_i[1] = a_if.req_signed_mode_i[1];
  assign f_if.req_op_a_i[0]        = a_if.req_op_a_i[0];
  assign f_if.req_op_a_i[1]        = a_if.req_op_a_i[1];
  assign f_if.req_op_b_i[0]        = a_if.req_op_b_i[0];
  assign f_if.req_op_b_i[1]        = a_if.req_op_b_i[1];

  logic fmon = 1'b0;
  int   f_g0 = 0;
  int   f_g1 = 0;
  always @(negedge clk) begin
    if (fmon) begin
      if (f_if.req_ready_o[0]) f_g0 <= f_g0 + 1;
      if (f_if.req_ready_o[1]) f_g1 <= f_g1 + 1;
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 2; i++) begin
      a_if.req_operator_i[i]    = MUL_M32;
      a_if.req_signed_mode_i[i] = 2'b00;
      a_if.req_op_a_i[i]        = 32'h0;
      a_if.req_op_b_i[i]        = 32'h0;
    end
    a_if.req_valid_i  = 2'b00;
    a_if.req_kill_i   = 2'b00;
    a_if.resp_ready_i = 2'b00;
  endtask

  task automatic set_req(input int p, input mul_opcode_e op, input logic [1:0] sm,
                         input logic [31:0] a, input logic [31:0] b);
    a_if.req_operator_i[p]    = op;
    a_if.req_signed_mode_i[p] = sm;
    a_if.req_op_a_i[p]        = a;
    a_if.req_op_b_i[p]        = b;
    a_if.req_valid_i[p]       = 1'b1;
  endtask

  // Counts cycles from now until resp_valid_o[p]; lat = -1 when the bound expires.
  task automatic await_resp(input int p, input int start, output int lat,
                            output logic [31:0] res);
    lat = start;
    while (!a_if.resp_valid_o[p] && lat < 30) begin
      tick();
      lat++;
    end
    if (!a_if.resp_valid_o[p]) lat = -1;
    res = a_if.resp_result_o;
  endtask

  task automatic ack(input int p);
    a_if.resp_ready_i[p] = 1'b1;
    tick();
    a_if.resp_ready_i[p] = 1'b0;
    #1;
  endtask

  // Issues one request from an idle arbiter and collects its response.
  task automatic run_op(input int p, input mul_opcode_e op, input logic [1:0] sm,
                        input logic [31:0] a, input logic [31:0] b,
                        output logic [1:0] rdy, output int lat, output logic [31:0] res);
    set_req(p, op, sm, a, b);
    #1;
    rdy = a_if.req_ready_o;
    tick();
    a_if.req_valid_i[p] = 1'b0;
    await_resp(p, 1, lat, res);
    if (lat > 0) ack(p);
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    idle_inputs();
    #12;
    checks++;
    if ({a_if.req_ready_o, a_if.resp_valid_o, a_if.mul_valid_o, a_if.mul_ready_o, a_if.busy_o} !== 7'b0)
      begin errors++; $display("FAIL reset_ctrl: got %b expected 0",
        {a_if.req_ready_o, a_if.resp_valid_o, a_if.mul_valid_o, a_if.mul_ready_o, a_if.busy_o}); end
    checks++;
    if ({a_if.mul_op_a_o, a_if.mul_op_b_o, a_if.resp_result_o} !== 96'b0)
      begin errors++; $display("FAIL reset_data: a=%h b=%h res=%h expected 0",
        a_if.mul_op_a_o, a_if.mul_op_b_o, a_if.resp_result_o); end
    checks++;
    if ({a_if.mul_operator_o, a_if.mul_signed_mode_o} !== 5'b0)
      begin errors++; $display("FAIL reset_op: got %b expected 0",
        {a_if.mul_operator_o, a_if.mul_signed_mode_o}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_mul();
    logic [1:0] rdy; int lat; logic [31:0] res;
    run_op(0, MUL_M32, 2'b00, 32'd3, 32'd5, rdy, lat, res);
    checks++;
    if (rdy !== 2'b01) begin errors++; $display("FAIL mul_grant: got %b expected 01", rdy); end
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL mul_latency: got %0d expected 2", lat); end
    checks++;
    if (res !== 32'h0000000F) begin errors++; $display("FAIL mul_result: got %h expected 0000000f", res); end
    checks++;
    if (a_if.busy_o !== 1'b0) begin errors++; $display("FAIL mul_busy_after: got %b expected 0", a_if.busy_o); end
  endtask

  task automatic test_mulh();
    int lat; int busy_cycles; int unstable; logic [31:0] res;
    set_req(1, MUL_H, 2'b00, 32'h80000000, 32'h80000000);
    #1;
    checks++;
    if (a_if.req_ready_o !== 2'b10) begin errors++; $display("FAIL mulh_grant: got %b expected 10", a_if.req_ready_o); end
    tick();
    a_if.req_valid_i = 2'b00;
    lat = 1; busy_cycles = 0; unstable = 0;
    while (!a_if.resp_valid_o[1] && lat < 30) begin
      if (a_if.mul_valid_o) begin
        busy_cycles++;
        if (a_if.mul_op_a_o !== 32'h80000000 || a_if.mul_op_b_o !== 32'h80000000) unstable++;
      end
      tick();
      lat++;
    end
    if (!a_if.resp_valid_o[1]) lat = -1;
    res = a_if.resp_result_o;
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL mulh_latency: got %0d expected 5", lat); end
    checks++;
    if (res !== 32'h40000000) begin errors++; $display("FAIL mulh_result: got %h expected 40000000", res); end
    checks++;
    if (busy_cycles !== 4 || unstable !== 0)
      begin errors++; $display("FAIL mulh_hold: busy=%0d unstable=%0d expected 4/0", busy_cycles, unstable); end
    ack(1);
  endtask

  task automatic test_contention();
    int exp_port [4] = '{0, 1, 0, 1};
    int lat; int w; int g; logic [31:0] res;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    f_g0 = 0; f_g1 = 0; fmon = 1'b1;
    set_req(0, MUL_CLMUL, 2'b00, 32'd3, 32'd3);
    set_req(1, MUL_CLMUL, 2'b00, 32'd3, 32'd3);
    #1;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (a_if.req_ready_o === 2'b00 && w < 10) begin tick(); w++; end
      g = a_if.req_ready_o[1] ? 1 : 0;
      checks++;
      if (a_if.req_ready_o !== (exp_port[k] == 1 ? 2'b10 : 2'b01))
        begin errors++; $display("FAIL rr_order[%0d]: got %b expected port %0d", k, a_if.req_ready_o, exp_port[k]); end
      tick();
      await_resp(g, 1, lat, res);
      checks++;
      if (res !== 32'h00000005 || lat !== 2)
        begin errors++; $display("FAIL rr_result[%0d]: got %h lat %0d expected 00000005 lat 2", k, res, lat); end
      ack(g);
    end
    a_if.req_valid_i = 2'b00;
    fmon = 1'b0;
    checks++;
    if (f_g1 !== 0 || f_g0 < 3)
      begin errors++; $display("FAIL fixed_prio: port0 grants %0d port1 grants %0d expected >=3/0", f_g0, f_g1); end
    repeat (4) tick();
  endtask

  task automatic test_kill();
    logic [1:0] rdy; int lat; int seen; logic [31:0] res; logic [31:0] a; logic [31:0] b;
    set_req(0, MUL_H, 2'b11, $urandom, $urandom);
    #1;
    tick();
    a_if.req_valid_i = 2'b00;
    tick();
    a_if.req_kill_i[0] = 1'b1;
    tick();
    a_if.req_kill_i[0] = 1'b0;
    #1;
    checks++;
    if (a_if.mul_valid_o !== 1'b0 || a_if.busy_o !== 1'b0)
      begin errors++; $display("FAIL kill_busy: mul_valid=%b busy=%b expected 0/0", a_if.mul_valid_o, a_if.busy_o); end
    seen = 0;
    repeat (6) begin if (a_if.resp_valid_o !== 2'b00) seen++; tick(); end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL kill_no_resp: resp cycles %0d expected 0", seen); end
    // Port 0 stays killed: it must be masked in IDLE and ignored as non-owner.
    a = $urandom; b = $urandom;
    a_if.req_kill_i = 2'b01;
    set_req(0, MUL_M32, 2'b00, 32'd1, 32'd1);
    run_op(1, MUL_H, 2'b11, a, b, rdy, lat, res);
    a_if.req_kill_i = 2'b00;
    a_if.req_valid_i = 2'b00;
    checks++;
    if (rdy !== 2'b10) begin errors++; $display("FAIL kill_mask: got %b expected 10", rdy); end
    checks++;
    if (lat !== 5 || res !== mul_ref(MUL_H, 2'b11, a, b))
      begin errors++; $display("FAIL kill_next: got %h lat %0d expected %h lat 5", res, lat, mul_ref(MUL_H, 2'b11, a, b)); end
  endtask

  task automatic test_kill_on_result();
    logic [31:0] prev; int seen;
    prev = a_if.resp_result_o;
    set_req(1, MUL_M32, 2'b00, 32'd7, 32'd9);
    #1;
    tick();
    a_if.req_valid_i = 2'b00;
    a_if.req_kill_i[1] = 1'b1;
    tick();
    a_if.req_kill_i[1] = 1'b0;
    #1;
    checks++;
    if (a_if.busy_o !== 1'b0 || a_if.resp_result_o !== prev)
      begin errors++; $display("FAIL kill_vs_result: busy=%b res=%h expected 0/%h", a_if.busy_o, a_if.resp_result_o, prev); end
    seen = 0;
    repeat (4) begin if (a_if.resp_valid_o !== 2'b00) seen++; tick(); end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL kill_vs_result_resp: resp cycles %0d expected 0", seen); end
  endtask

  task automatic test_backpressure();
    logic [31:0] a; logic [31:0] b; logic [31:0] a2; logic [31:0] b2; logic [31:0] res;
    int lat; int bad;
    a = $urandom; b = $urandom; a2 = $urandom; b2 = $urandom;
    set_req(0, MUL_M32, 2'b00, a, b);
    #1;
    tick();
    a_if.req_valid_i = 2'b00;
    await_resp(0, 1, lat, res);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL bp_latency: got %0d expected 2", lat); end
    set_req(1, MUL_CLMULH, 2'b00, a2, b2);
    #1;
    bad = 0;
    repeat (10) begin
      if (a_if.resp_valid_o !== 2'b01 || a_if.resp_result_o !== a * b || a_if.req_ready_o !== 2'b00) bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL bp_hold: bad cycles %0d expected 0", bad); end
    a_if.req_kill_i[0]   = 1'b1;
    a_if.resp_ready_i[0] = 1'b1;
    tick();
    a_if.req_kill_i[0]   = 1'b0;
    a_if.resp_ready_i[0] = 1'b0;
    #1;
    checks++;
    if (a_if.busy_o !== 1'b0 || a_if.req_ready_o !== 2'b10)
      begin errors++; $display("FAIL bp_kill_ack: busy=%b ready=%b expected 0/10", a_if.busy_o, a_if.req_ready_o); end
    tick();
    a_if.req_valid_i = 2'b00;
    await_resp(1, 1, lat, res);
    checks++;
    if (res !== mul_ref(MUL_CLMULH, 2'b00, a2, b2) || lat !== 2)
      begin errors++; $display("FAIL bp_port1: got %h lat %0d expected %h lat 2", res, lat, mul_ref(MUL_CLMULH, 2'b00, a2, b2)); end
    if (lat > 0) ack(1);
  endtask

  task automatic test_random();
    mul_opcode_e op [2]; logic [1:0] sm [2]; logic [31:0] a [2]; logic [31:0] b [2];
    int last; int p; int w; int lat; int exp_lat; logic both; logic [31:0] res; logic [1:0] rdy;
    last = 0;
    for (int i = 0; i < 40; i++) begin
      p = $urandom_range(0, 1);
      both = (i > 0) && ($urandom_range(0, 3) == 0);
      for (int j = 0; j < 2; j++) begin
        op[j] = mul_opcode_e'($urandom_range(0, 4));
        sm[j] = 2'($urandom_range(0, 3));
        a[j]  = $urandom;
        b[j]  = $urandom;
      end
      set_req(p, op[p], sm[p], a[p], b[p]);
      if (both) set_req(1 - p, op[1 - p], sm[1 - p], a[1 - p], b[1 - p]);
      w = both ? 1 - last : p;
      exp_lat = (op[w] == MUL_H) ? 5 : 2;
      #1;
      rdy = a_if.req_ready_o;
      tick();
      a_if.req_valid_i = 2'b00;
      await_resp(w, 1, lat, res);
      checks++;
      if (rdy !== (w == 1 ? 2'b10 : 2'b01))
        begin errors++; $display("FAIL rnd_grant[%0d]: got %b expected port %0d", i, rdy, w); end
      checks++;
      if (lat !== exp_lat) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", i, lat, exp_lat); end
      checks++;
      if (res !== mul_ref(op[w], sm[w], a[w], b[w]))
        begin errors++; $display("FAIL rnd_result[%0d]: got %h expected %h", i, res, mul_ref(op[w], sm[w], a[w], b[w])); end
      if (lat > 0) ack(w);
      last = w;
    end
  endtask

  task automatic test_reset_busy();
    int lat; logic [31:0] res;
    set_req(0, MUL_H, 2'b01, 32'h12345678, 32'h9abcdef0);
    #1;
    tick();
    a_if.req_valid_i = 2'b00;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_if.req_ready_o, a_if.resp_valid_o, a_if.mul_valid_o, a_if.mul_ready_o, a_if.busy_o} !== 7'b0)
      begin errors++; $display("FAIL async_reset_ctrl: got %b expected 0",
        {a_if.req_ready_o, a_if.resp_valid_o, a_if.mul_valid_o, a_if.mul_ready_o, a_if.busy_o}); end
    checks++;
    if ({a_if.mul_op_a_o, a_if.mul_op_b_o, a_if.resp_result_o} !== 96'b0)
      begin errors++; $display("FAIL async_reset_data: a=%h b=%h res=%h expected 0",
        a_if.mul_op_a_o, a_if.mul_op_b_o, a_if.resp_result_o); end
    #2;
    rst_n = 1'b1;
    set_req(0, MUL_M32, 2'b00, 32'd6, 32'd7);
    set_req(1, MUL_M32, 2'b00, 32'd8, 32'd9);
    #1;
    checks++;
    if (a_if.req_ready_o !== 2'b01) begin errors++; $display("FAIL post_reset_grant: got %b expected 01", a_if.req_ready_o); end
    tick();
    a_if.req_valid_i = 2'b00;
    await_resp(0, 1, lat, res);
    checks++;
    if (res !== 32'd42 || lat !== 2) begin errors++; $display("FAIL post_reset_result: got %h lat %0d expected 0000002a lat 2", res, lat); end
    if (lat > 0) ack(0);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_mul();
    test_mulh();
    test_contention();
    test_kill();
    test_kill_on_result();
    test_backpressure();
    test_random();
    test_reset_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
